// File: rtl/write_strobe_decoder.sv
// CPU write decoder for the CAN register file: one registered one-hot strobe per request.
// Optional write protection with a two-step unlock key is enabled by defining WRITE_LOCK_EN.
module write_strobe_decoder #(
   parameter int                  ADDR_W      = 5,
   parameter int                  NUM_REGS    = 15,
   parameter int                  BASE_ADDR   = 4,
   parameter logic [NUM_REGS-1:0] PROT_MASK   = 15'h0800,
   parameter int                  UNLOCK_ADDR = 31
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   address,
   input  logic                activ_in,
   output logic [NUM_REGS-1:0] activ_out,
   output logic                ack,
   output logic                err,
   output logic                locked
);

   generate
      if (BASE_ADDR + NUM_REGS > 2 ** ADDR_W) begin : g_bad_map
         $error("write_strobe_decoder: BASE_ADDR+NUM_REGS exceeds the address space");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

   localparam logic [ADDR_W:0] BASE_X = (ADDR_W + 1)'(BASE_ADDR);
   localparam logic [ADDR_W:0] NUM_X  = (ADDR_W + 1)'(NUM_REGS);

   state_t              state_reg, state_next;
   logic [NUM_REGS-1:0] strobe_reg, strobe_next;
   logic                ack_reg, ack_next;
   logic                err_reg, err_next;

   logic [ADDR_W:0]     addr_x;
   logic [ADDR_W:0]     off;
   logic                in_map;
   logic [NUM_REGS-1:0] onehot;

   // Offset is one bit wider so addresses below BASE_ADDR never alias into the map.
   assign addr_x = {1'b0, address};
   assign off    = addr_x - BASE_X;
   assign in_map = (addr_x >= BASE_X) && (off < NUM_X);

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
         assign onehot[gi] = in_map && (off == (ADDR_W + 1)'(gi));
      end
   endgenerate

`ifdef WRITE_LOCK_EN
   logic locked_reg, locked_next;
   logic seq_reg, seq_next;
   logic prot_hit;
   logic key_hit;

   assign prot_hit = |(onehot & PROT_MASK);
   assign key_hit  = (address == ADDR_W'(UNLOCK_ADDR));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         locked_reg <= 1'b1;
         seq_reg    <= 1'b0;
      end else begin
         locked_reg <= locked_next;
         seq_reg    <= seq_next;
      end
   end

   assign locked = locked_reg;
`else
   assign locked = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg  <= HOLD;
         strobe_reg <= '0;
         ack_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         strobe_reg <= strobe_next;
         ack_reg    <= ack_next;
         err_reg    <= err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      strobe_next = '0;
      ack_next    = 1'b0;
      err_next    = 1'b0;
`ifdef WRITE_LOCK_EN
      locked_next = locked_reg;
      seq_next    = seq_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (activ_in) begin
               state_next = STROBE;
               ack_next   = 1'b1;
`ifdef WRITE_LOCK_EN
               if (key_hit) begin
                  // Second consecutive key request opens the lock.
                  if (seq_reg) begin
                     locked_next = 1'b0;
                     seq_next    = 1'b0;
                  end else begin
                     seq_next = 1'b1;
                  end
               end else begin
                  seq_next = 1'b0;
                  if (!in_map || (prot_hit && locked_reg)) begin
                     err_next = 1'b1;
                  end else begin
                     strobe_next = onehot;
                     if (prot_hit) begin
                        locked_next = 1'b1;
                     end
                  end
               end
`else
               if (in_map) begin
                  strobe_next = onehot;
               end else begin
                  err_next = 1'b1;
               end
`endif
            end
         end
         STROBE: begin
            state_next = activ_in ? HOLD : IDLE;
         end
         HOLD: begin
            if (!activ_in) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = HOLD;
         end
      endcase
   end

   assign activ_out = strobe_reg;
   assign ack       = ack_reg;
   assign err       = err_reg;

endmodule
